// File: rtl/match_tally.sv
// match_tally: round/match tally for an LED-bar game with a 4-digit scanned display.
// Optional build macro TALLY_BLINK_EN blinks the winner's digits once the match is decided.
module match_tally #(
  parameter int unsigned WIN_HOLD   = 8,
  parameter int unsigned MATCH_WINS = 3,
  parameter int unsigned SCAN_DIV   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] led_in,
  input  logic       clr_match,
  output logic       win_left,
  output logic       win_right,
  output logic [3:0] left_cnt,
  output logic [3:0] right_cnt,
  output logic       match_over,
  output logic       winner,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int unsigned HOLD_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DIV_W  = 8;

  localparam logic [HOLD_W-1:0] HOLD_N  = HOLD_W'(WIN_HOLD);
  localparam logic [CNT_W-1:0]  MATCH_N = CNT_W'(MATCH_WINS);
  localparam logic [DIV_W-1:0]  DIV_N   = DIV_W'(SCAN_DIV);

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_L     = 7'b1000111;
  localparam logic [6:0] GLYPH_R     = 7'b0101111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  typedef enum logic [1:0] {ARMED, QUAL, COUNTED, DONE} state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                side_q, side_d;      // 1 = left end latched
  logic [CNT_W-1:0]    left_d, right_d;
  logic                win_left_d, win_right_d, match_over_d, winner_d;
  logic                hit, hit_side, done_now;
  logic [HOLD_W-1:0]   hold_inc;

  logic [DIV_W-1:0]    div_q;
  logic [1:0]          idx_q;
  logic [3:0]          an_d;
  logic [6:0]          seg_d;
  logic                blank_c;

  logic clear;
  logic pat_left, pat_right, pat_any, same;

  assign clear     = rst | clr_match;
  assign pat_left  = (led_in == 7'b1000000);
  assign pat_right = (led_in == 7'b0000001);
  assign pat_any   = pat_left | pat_right;
  assign same      = pat_any & (pat_left == side_q);
  assign hold_inc  = hold_q + HOLD_W'(1);

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (clear) state_q <= ARMED;
    else       state_q <= state_d;
  end

  // Next-state and next tally values
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    side_d       = side_q;
    left_d       = left_cnt;
    right_d      = right_cnt;
    win_left_d   = 1'b0;
    win_right_d  = 1'b0;
    match_over_d = match_over;
    winner_d     = winner;
    hit          = 1'b0;
    hit_side     = side_q;
    done_now     = 1'b0;

    case (state_q)
      ARMED: begin
        if (pat_any) begin
          side_d   = pat_left;
          hit_side = pat_left;
          hold_d   = HOLD_W'(1);
          if (HOLD_N == HOLD_W'(1)) hit = 1'b1;
          else                      state_d = QUAL;
        end
      end
      QUAL: begin
        if (same) begin
          hold_d = hold_inc;
          if (hold_inc == HOLD_N) hit = 1'b1;
        end else begin
          state_d = ARMED;
          hold_d  = '0;
        end
      end
      COUNTED: begin
        if (!same) state_d = ARMED;
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = ARMED;
    endcase

    if (hit) begin
      hold_d = '0;
      if (hit_side) begin
        left_d     = left_cnt + CNT_W'(1);
        win_left_d = 1'b1;
        done_now   = (left_d == MATCH_N);
      end else begin
        right_d     = right_cnt + CNT_W'(1);
        win_right_d = 1'b1;
        done_now    = (right_d == MATCH_N);
      end
      state_d = done_now ? DONE : COUNTED;
      if (done_now) begin
        match_over_d = 1'b1;
        winner_d     = hit_side;
      end
    end
  end

  // Tally registers; clear wins over any qualifying sample on the same edge
  always_ff @(posedge clk) begin
    if (clear) begin
      hold_q     <= '0;
      side_q     <= 1'b0;
      left_cnt   <= '0;
      right_cnt  <= '0;
      win_left   <= 1'b0;
      win_right  <= 1'b0;
      match_over <= 1'b0;
      winner     <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      side_q     <= side_d;
      left_cnt   <= left_d;
      right_cnt  <= right_d;
      win_left   <= win_left_d;
      win_right  <= win_right_d;
      match_over <= match_over_d;
      winner     <= winner_d;
    end
  end

  // Scan position: idx 0..3 selects an[3]..an[0], advancing every SCAN_DIV+1 cycles
  always_ff @(posedge clk) begin
    if (clear) begin
      div_q <= '0;
      idx_q <= 2'd0;
    end else if (div_q == DIV_N) begin
      div_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

`ifdef TALLY_BLINK_EN
  logic [7:0] blink_q;

  // Free-running blink timer
  always_ff @(posedge clk) begin
    if (clear) blink_q <= '0;
    else       blink_q <= blink_q + 8'd1;
  end

  assign blank_c = match_over & blink_q[7] &
                   (winner ? (idx_q == 2'd0 || idx_q == 2'd1)
                           : (idx_q == 2'd2 || idx_q == 2'd3));
`else
  assign blank_c = 1'b0;
`endif

  // Digit content for the current scan position
  always_comb begin
    an_d  = 4'b1111;
    seg_d = GLYPH_BLANK;
    case (idx_q)
      2'd0: begin
        an_d  = 4'b0111;
        seg_d = hex_glyph(left_cnt);
      end
      2'd1: begin
        an_d = 4'b1011;
        if (match_over && winner) seg_d = GLYPH_L;
      end
      2'd2: begin
        an_d = 4'b1101;
        if (match_over && !winner) seg_d = GLYPH_R;
      end
      default: begin
        an_d  = 4'b1110;
        seg_d = hex_glyph(right_cnt);
      end
    endcase
    if (blank_c) seg_d = GLYPH_BLANK;
  end

  // Display output registers
  always_ff @(posedge clk) begin
    if (clear) begin
      an  <= 4'b0111;
      seg <= GLYPH_0;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule
